// File: rtl/fakeram7_256x32_arb.sv
// fakeram7_256x32_arb: round-robin A/B arbiter sharing one fakeram7_256x32 single-port macro
//  Ports: clk, rst_n (async active-low)
//         a_req_{valid,ready,we,addr,wdata}, a_resp_{valid,we,rdata}, same b_*
//         ram_{ce,we,addr,wd} to the macro, ram_rd from the macro
//  Option: SRAM_ARB_RDATA_REG_EN registers ram_rd and the response tag (latency 2 instead of 1)
module fakeram7_256x32_arb #(
  parameter int BITS       = 32,
  parameter int WORD_DEPTH = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_we,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [BITS-1:0]       a_req_wdata,
  output logic                  a_resp_valid,
  output logic                  a_resp_we,
  output logic [BITS-1:0]       a_resp_rdata,
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic                  b_req_we,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  input  logic [BITS-1:0]       b_req_wdata,
  output logic                  b_resp_valid,
  output logic                  b_resp_we,
  output logic [BITS-1:0]       b_resp_rdata,
  output logic                  ram_ce,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [BITS-1:0]       ram_wd,
  input  logic [BITS-1:0]       ram_rd
);
  if (WORD_DEPTH > (1 << ADDR_WIDTH)) begin : g_depth_chk
    $error("WORD_DEPTH exceeds address space");
  end
  logic rst_q, last_q, ga, gb;
  logic tag_v, tag_p, tag_we;
  logic o_v, o_p, o_we;
  logic [BITS-1:0] o_d;
  always_comb begin
    ga = rst_q & a_req_valid & (~b_req_valid | last_q);
    gb = rst_q & b_req_valid & (~a_req_valid | ~last_q);
  end
  assign a_req_ready = ga;
  assign b_req_ready = gb;
  // Every ram_* input is forced to 0 when idle so the macro never sees X.
  always_comb begin
    ram_ce   = ga | gb;
    ram_we   = ga ? a_req_we : gb ? b_req_we : 1'b0;
    ram_addr = ga ? a_req_addr : gb ? b_req_addr : '0;
    ram_wd   = (ga & a_req_we) ? a_req_wdata : (gb & b_req_we) ? b_req_wdata : '0;
  end
  // last_q = 1 means B was granted most recently; tag_p = 1 means the tag belongs to B.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rst_q  <= 1'b0;
      last_q <= 1'b1;
      tag_v  <= 1'b0;
      tag_p  <= 1'b0;
      tag_we <= 1'b0;
    end else begin
      rst_q  <= 1'b1;
      if (ga | gb) last_q <= gb;
      tag_v  <= ga | gb;
      tag_p  <= gb;
      tag_we <= ram_we;
    end
`ifdef SRAM_ARB_RDATA_REG_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      o_v  <= 1'b0;
      o_p  <= 1'b0;
      o_we <= 1'b0;
      o_d  <= '0;
    end else begin
      o_v  <= tag_v;
      o_p  <= tag_p;
      o_we <= tag_we;
      o_d  <= (tag_v & ~tag_we) ? ram_rd : '0;
    end
`else
  always_comb begin
    o_v  = tag_v;
    o_p  = tag_p;
    o_we = tag_we;
    o_d  = (tag_v & ~tag_we) ? ram_rd : '0;
  end
`endif
  always_comb begin
    a_resp_valid = o_v & ~o_p;
    b_resp_valid = o_v & o_p;
    a_resp_we    = a_resp_valid & o_we;
    b_resp_we    = b_resp_valid & o_we;
    a_resp_rdata = a_resp_valid ? o_d : '0;
    b_resp_rdata = b_resp_valid ? o_d : '0;
  end
endmodule

// File: tb/tb_fakeram7_256x32_arb.sv
// tb_fakeram7_256x32_arb: directed + random check of the A/B macro arbiter against a reference model
module tb_fakeram7_256x32_arb;
`ifdef SRAM_ARB_RDATA_REG_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif
  localparam int N = 4096;
  logic clk = 0, rst_n = 0;
  logic a_req_valid = 0, a_req_we = 0, b_req_valid = 0, b_req_we = 0;
  logic [7:0] a_req_addr = 0, b_req_addr = 0;
  logic [31:0] a_req_wdata = 0, b_req_wdata = 0;
  logic a_req_ready, a_resp_valid, a_resp_we, b_req_ready, b_resp_valid, b_resp_we;
  logic [31:0] a_resp_rdata, b_resp_rdata;
  logic ram_ce, ram_we;
  logic [7:0] ram_addr;
  logic [31:0] ram_wd, ram_rd;
  always #5 clk = ~clk;
  fakeram7_256x32_arb dut (
    .clk(clk), .rst_n(rst_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .a_resp_valid(a_resp_valid), .a_resp_we(a_resp_we), .a_resp_rdata(a_resp_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .b_resp_valid(b_resp_valid), .b_resp_we(b_resp_we), .b_resp_rdata(b_resp_rdata),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wd(ram_wd), .ram_rd(ram_rd)
  );
  // Behavioural single-port macro: one-cycle synchronous read, no reset, X until first read.
  logic [31:0] mac_mem [256];
  always @(posedge clk)
    if (ram_ce) begin
      if (ram_we) mac_mem[ram_addr] <= ram_wd;
      else ram_rd <= mac_mem[ram_addr];
    end
  // Reference model state
  bit run, last_b;
  bit [31:0] ref_mem [256];
  bit ev_a [N], ev_b [N], ew_a [N], ew_b [N];
  bit [31:0] ed_a [N], ed_b [N];
  int cyc, n_assert, n_fail;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask
  task automatic step(input bit rn,
                      input bit av, input bit awe, input bit [7:0] aad, input bit [31:0] awd,
                      input bit bv, input bit bwe, input bit [7:0] bad, input bit [31:0] bwd,
                      output bit ga, output bit gb);
    @(negedge clk);
    rst_n = rn;
    a_req_valid = av; a_req_we = awe; a_req_addr = aad; a_req_wdata = awd;
    b_req_valid = bv; b_req_we = bwe; b_req_addr = bad; b_req_wdata = bwd;
    #2;
    if (!rn) begin
      run = 0;
      last_b = 1;
      for (int i = cyc; i < cyc + 4; i++) begin
        ev_a[i] = 0;
        ev_b[i] = 0;
      end
    end
    ga = run && av && (!bv || last_b);
    gb = run && bv && (!av || !last_b);
    chk("a_req_ready", a_req_ready, ga);
    chk("b_req_ready", b_req_ready, gb);
    chk("ram_ce", ram_ce, ga || gb);
    chk("ram_we", ram_we, ga ? awe : gb ? bwe : 0);
    chk("ram_addr", ram_addr, ga ? aad : gb ? bad : 0);
    chk("ram_wd", ram_wd, (ga && awe) ? awd : (gb && bwe) ? bwd : 0);
    chk("a_resp_valid", a_resp_valid, ev_a[cyc]);
    chk("a_resp_we", a_resp_we, ev_a[cyc] && ew_a[cyc]);
    chk("a_resp_rdata", a_resp_rdata, ev_a[cyc] ? ed_a[cyc] : 0);
    chk("b_resp_valid", b_resp_valid, ev_b[cyc]);
    chk("b_resp_we", b_resp_we, ev_b[cyc] && ew_b[cyc]);
    chk("b_resp_rdata", b_resp_rdata, ev_b[cyc] ? ed_b[cyc] : 0);
    if (ga) begin
      ev_a[cyc+L] = 1; ew_a[cyc+L] = awe; ed_a[cyc+L] = awe ? 0 : ref_mem[aad];
      if (awe) ref_mem[aad] = awd;
      last_b = 0;
    end
    if (gb) begin
      ev_b[cyc+L] = 1; ew_b[cyc+L] = bwe; ed_b[cyc+L] = bwe ? 0 : ref_mem[bad];
      if (bwe) ref_mem[bad] = bwd;
      last_b = 1;
    end
    run = rn;
    cyc++;
  endtask
  task automatic idle(input int n);
    bit ga, gb;
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, ga, gb);
  endtask
  task automatic do_reset(input int n);
    bit ga, gb;
    for (int i = 0; i < n; i++) step(0, 1, 0, 8'h05, 0, 1, 1, 8'h06, 32'h1, ga, gb);
  endtask
  bit ga, gb, ok;
  bit pa, pb, pawe, pbwe;
  bit [7:0] paad, pbad;
  bit [31:0] pawd, pbwd;
  int first_b;
  initial begin
    for (int i = 0; i < 256; i++) begin
      mac_mem[i] = 0;
      ref_mem[i] = 0;
    end
    run = 0; last_b = 1; cyc = 0; n_assert = 0; n_fail = 0;
    do_reset(2);
    idle(2);
    // Single-port write then read-back
    step(1, 1, 1, 8'h10, 32'hDEADBEEF, 0, 0, 0, 0, ga, gb);
    chk("t1_write_granted", ga, 1);
    step(1, 1, 0, 8'h10, 0, 0, 0, 0, 0, ga, gb);
    idle(3);
    // Tie right after reset: A first, then alternate
    do_reset(1);
    step(1, 1, 0, 8'h01, 0, 1, 0, 8'h02, 0, ga, gb);
    chk("t2_no_grant_before_run", ga || gb, 0);
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 0, 8'h01, 0, 1, 0, 8'h02, 0, ga, gb);
      chk("t2_alternate", ga, (i % 2) == 0);
    end
    idle(3);
    // B back-to-back reads with A idle
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 0, 1, 0, 8'(i), 0, ga, gb);
      chk("t4_b_granted", gb, 1);
    end
    idle(3);
    // Reset the cycle after a read is accepted
    step(1, 1, 0, 8'h10, 0, 0, 0, 0, 0, ga, gb);
    do_reset(2);
    step(1, 1, 0, 8'h03, 0, 1, 0, 8'h04, 0, ga, gb);
    step(1, 1, 0, 8'h03, 0, 1, 0, 8'h04, 0, ga, gb);
    chk("t5_a_wins_tie", ga, 1);
    step(1, 0, 0, 0, 0, 1, 0, 8'h04, 0, ga, gb);
    idle(3);
    // Random traffic: requesters hold payload until accepted
    pa = 0; pb = 0;
    for (int i = 0; i < 800; i++) begin
      if (!pa && $urandom_range(0, 3) != 0) begin
        pa = 1; pawe = $urandom_range(0, 1); paad = 8'($urandom_range(0, 7)); pawd = $urandom;
      end
      if (!pb && $urandom_range(0, 3) != 0) begin
        pb = 1; pbwe = $urandom_range(0, 1); pbad = 8'($urandom_range(0, 7)); pbwd = $urandom;
      end
      ok = $urandom_range(0, 99) != 0;
      step(ok, pa, pawe, paad, pawd, pb, pbwe, pbad, pbwd, ga, gb);
      if (ga) pa = 0;
      if (gb) pb = 0;
    end
    idle(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
